// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: RV32I opcodes, control-bundle types and the funct3-to-ALU mapping
// shared by the decode stage and its combinational decoder.
package rv_ctrl_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR = 4'd3,
        ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_MUL = 4'd11, ALU_MULH = 4'd12,
        ALU_MULHSU = 4'd13, ALU_MULHU = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2} src_a_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        src_a_e      src_a;
        logic        src_b;
        wb_sel_e     wb_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [2:0]  funct3;
        logic        illegal;
    } ctrl_t;

    // alt selects SUB over ADD and SRA/SRAI over SRL/SRLI
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: fetch-side and execute-side handshake plus control bundle
// of the decode stage; master drives fetch/execute inputs, slave is the stage.
interface rv_decode_stage_if #(parameter int PC_W = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic [3:0]      out_alu_op;
    logic [1:0]      out_src_a;
    logic            out_src_b;
    logic [1:0]      out_wb_sel;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic [2:0]      out_funct3;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
               out_src_a, out_src_b, out_wb_sel, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_jump, out_funct3, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
               out_src_a, out_src_b, out_wb_sel, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_jump, out_funct3, out_illegal
    );
endinterface

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32I(+optional MUL) decoder producing the control
// bundle with immediate, plus which source registers the instruction reads.
module rv_decode_comb import rv_ctrl_pkg::*; #(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2
);
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_bad;

    assign w_op    = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'd0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_ctrl        = '0;
        o_ctrl.rs1    = i_instr[19:15];
        o_ctrl.rs2    = i_instr[24:20];
        o_ctrl.rd     = i_instr[11:7];
        o_ctrl.funct3 = w_f3;
        o_uses_rs1    = 1'b1;
        o_uses_rs2    = 1'b0;
        w_bad         = 1'b0;
        case (w_op)
            OP_REG: begin
                o_ctrl.src_b     = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs2       = 1'b1;
                o_ctrl.alu_op    = alu_from_f3(w_f3, w_f7 == F7_ALT);
                if (w_f7 == F7_MULDIV) begin
                    o_ctrl.alu_op = alu_op_e'(4'd11 + {2'b00, w_f3[1:0]});
                    w_bad         = !ENABLE_M || w_f3[2];
                end else if (w_f7 == F7_ALT)
                    w_bad = !(w_f3 == 3'd0 || w_f3 == 3'd5);
                else
                    w_bad = w_f7 != F7_BASE;
            end
            OP_IMM: begin
                o_ctrl.imm       = w_imm_i;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = alu_from_f3(w_f3, w_f3 == 3'd5 && i_instr[30]);
                w_bad            = (w_f3 == 3'd1 && w_f7 != F7_BASE) ||
                                   (w_f3 == 3'd5 && w_f7 != F7_BASE && w_f7 != F7_ALT);
            end
            OP_LOAD: begin
                o_ctrl.imm       = w_imm_i;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.wb_sel    = WB_LOAD;
                o_ctrl.reg_write = 1'b1;
                w_bad            = w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7;
            end
            OP_STORE: begin
                o_ctrl.imm       = w_imm_s;
                o_ctrl.mem_write = 1'b1;
                o_uses_rs2       = 1'b1;
                w_bad            = w_f3 > 3'd2;
            end
            OP_BRANCH: begin
                o_ctrl.imm    = w_imm_b;
                o_ctrl.branch = 1'b1;
                o_ctrl.src_a  = SRC_A_PC;
                o_uses_rs2    = 1'b1;
                w_bad         = w_f3 == 3'd2 || w_f3 == 3'd3;
            end
            OP_JAL: begin
                o_ctrl.imm       = w_imm_j;
                o_ctrl.jump      = 1'b1;
                o_ctrl.src_a     = SRC_A_PC;
                o_ctrl.wb_sel    = WB_PC4;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs1       = 1'b0;
            end
            OP_JALR: begin
                o_ctrl.imm       = w_imm_i;
                o_ctrl.jump      = 1'b1;
                o_ctrl.wb_sel    = WB_PC4;
                o_ctrl.reg_write = 1'b1;
                w_bad            = w_f3 != 3'd0;
            end
            OP_LUI, OP_AUIPC: begin
                o_ctrl.imm       = w_imm_u;
                o_ctrl.src_a     = (w_op == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs1       = 1'b0;
            end
            default: begin
                w_bad      = 1'b1;
                o_uses_rs1 = 1'b0;
            end
        endcase
        if (o_ctrl.rd == 5'd0) o_ctrl.reg_write = 1'b0;
        if (w_bad) begin
            o_ctrl.illegal   = 1'b1;
            o_ctrl.reg_write = 1'b0;
            o_ctrl.mem_read  = 1'b0;
            o_ctrl.mem_write = 1'b0;
            o_ctrl.branch    = 1'b0;
            o_ctrl.jump      = 1'b0;
        end
    end
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered decode stage with valid/ready on both sides,
// load-use bubbling, flush and illegal-instruction flagging.
module rv_decode_stage import rv_ctrl_pkg::*; #(
    parameter int PC_W      = 32,
    parameter bit ENABLE_M  = 1'b0,
    parameter bit HAZARD_EN = 1'b1
) (
    input logic            clk,
    input logic            resetn,
    rv_decode_stage_if.slave bus
);
    ctrl_t           w_ctrl, r_ctrl;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;
    logic            w_uses_rs1, w_uses_rs2, w_hazard, w_ready;

    rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .i_instr   (bus.in_instr),
        .o_ctrl    (w_ctrl),
        .o_uses_rs1(w_uses_rs1),
        .o_uses_rs2(w_uses_rs2)
    );

    // a load still in the output register cannot forward to its immediate consumer
    assign w_hazard = HAZARD_EN && r_valid && r_ctrl.mem_read && r_ctrl.rd != 5'd0 && bus.in_valid &&
                      ((w_uses_rs1 && w_ctrl.rs1 == r_ctrl.rd) || (w_uses_rs2 && w_ctrl.rs2 == r_ctrl.rd));
    assign w_ready  = resetn && !bus.flush && !w_hazard && (!r_valid || bus.out_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= '0;
        end else if (bus.flush)
            r_valid <= 1'b0;
        else if (bus.in_valid && w_ready) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_pc    <= bus.in_pc;
        end else if (bus.out_ready)
            r_valid <= 1'b0;
    end

    assign bus.in_ready      = w_ready;
    assign bus.out_valid     = r_valid;
    assign bus.out_pc        = r_pc;
    assign bus.out_rs1       = r_ctrl.rs1;
    assign bus.out_rs2       = r_ctrl.rs2;
    assign bus.out_rd        = r_ctrl.rd;
    assign bus.out_imm       = r_ctrl.imm;
    assign bus.out_alu_op    = r_ctrl.alu_op;
    assign bus.out_src_a     = r_ctrl.src_a;
    assign bus.out_src_b     = r_ctrl.src_b;
    assign bus.out_wb_sel    = r_ctrl.wb_sel;
    assign bus.out_reg_write = r_ctrl.reg_write;
    assign bus.out_mem_read  = r_ctrl.mem_read;
    assign bus.out_mem_write = r_ctrl.mem_write;
    assign bus.out_branch    = r_ctrl.branch;
    assign bus.out_jump      = r_ctrl.jump;
    assign bus.out_funct3    = r_ctrl.funct3;
    assign bus.out_illegal   = r_ctrl.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed vectors against two stages side by side,
// a (ENABLE_M=0, HAZARD_EN=1) and b (ENABLE_M=1, HAZARD_EN=0).
module tb_rv_decode_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.PC_W(32)) ia ();
    rv_decode_stage_if #(.PC_W(32)) ib ();

    rv_decode_stage #(.PC_W(32), .ENABLE_M(1'b0), .HAZARD_EN(1'b1)) u_dut_a (.clk(clk), .resetn(resetn), .bus(ia));
    rv_decode_stage #(.PC_W(32), .ENABLE_M(1'b1), .HAZARD_EN(1'b0)) u_dut_b (.clk(clk), .resetn(resetn), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic va, input logic vb, input logic [31:0] instr, input logic [31:0] pc);
        ia.in_valid = va;
        ib.in_valid = vb;
        ia.in_instr = instr;
        ib.in_instr = instr;
        ia.in_pc    = pc;
        ib.in_pc    = pc;
        #1;
    endtask

    task automatic ctl(input logic fl, input logic ordy);
        ia.flush = fl;
        ib.flush = fl;
        ia.out_ready = ordy;
        ib.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctl(1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        step();
        step();
        @(negedge clk) resetn = 1'b1;
        // add x3,x1,x2 then sub x2,x1,x2
        drive(1'b1, 1'b1, 32'h002081B3, 32'h100);
        chk("add_in_ready", ia.in_ready, 1);
        step();
        chk("add_valid", ia.out_valid, 1);
        chk("add_alu", ia.out_alu_op, 0);
        chk("add_rd", ia.out_rd, 3);
        chk("add_src_b", ia.out_src_b, 1);
        chk("add_regw", ia.out_reg_write, 1);
        chk("add_pc", ia.out_pc, 32'h100);
        chk("add_wb", ia.out_wb_sel, 0);
        drive(1'b1, 1'b1, 32'h40208133, 32'h104);
        step();
        chk("sub_alu", ia.out_alu_op, 1);
        chk("sub_rd", ia.out_rd, 2);
        // lw x5,0(x1) then add x6,x5,x0: a bubbles once, b does not
        drive(1'b1, 1'b1, 32'h0000A283, 32'h108);
        step();
        chk("lw_mem_read", ia.out_mem_read, 1);
        chk("lw_wb", ia.out_wb_sel, 1);
        chk("lw_rd", ia.out_rd, 5);
        drive(1'b1, 1'b1, 32'h00028333, 32'h10C);
        chk("haz_a_in_ready", ia.in_ready, 0);
        chk("haz_b_in_ready", ib.in_ready, 1);
        step();
        chk("haz_a_bubble", ia.out_valid, 0);
        chk("haz_b_valid", ib.out_valid, 1);
        chk("haz_b_pc", ib.out_pc, 32'h10C);
        drive(1'b1, 1'b0, 32'h00028333, 32'h10C);
        chk("haz_a_ready_after", ia.in_ready, 1);
        step();
        chk("haz_a_valid", ia.out_valid, 1);
        chk("haz_a_pc", ia.out_pc, 32'h10C);
        chk("haz_a_rd", ia.out_rd, 6);
        chk("haz_b_idle", ib.out_valid, 0);
        // hold under backpressure then flush
        drive(1'b1, 1'b1, 32'h0000A283, 32'h200);
        step();
        ctl(1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", ia.in_ready, 0);
            step();
            chk("hold_valid", ia.out_valid, 1);
            chk("hold_pc", ia.out_pc, 32'h200);
            chk("hold_mem_read", ia.out_mem_read, 1);
        end
        ctl(1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h002081B3, 32'h204);
        chk("flush_in_ready", ia.in_ready, 0);
        step();
        chk("flush_valid", ia.out_valid, 0);
        ctl(1'b0, 1'b1);
        // illegal encodings and M extension
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h300);
        step();
        chk("ill_valid", ia.out_valid, 1);
        chk("ill_flag", ia.out_illegal, 1);
        chk("ill_regw", ia.out_reg_write, 0);
        chk("ill_memw", ia.out_mem_write, 0);
        drive(1'b1, 1'b1, 32'h023100B3, 32'h304);
        step();
        chk("mul_a_illegal", ia.out_illegal, 1);
        chk("mul_b_illegal", ib.out_illegal, 0);
        chk("mul_b_alu", ib.out_alu_op, 11);
        chk("mul_b_regw", ib.out_reg_write, 1);
        drive(1'b1, 1'b1, 32'h023140B3, 32'h308);
        step();
        chk("div_b_illegal", ib.out_illegal, 1);
        drive(1'b1, 1'b1, 32'h00000013, 32'h30C);
        step();
        chk("nop_regw", ia.out_reg_write, 0);
        chk("nop_illegal", ia.out_illegal, 0);
        drive(1'b1, 1'b1, 32'hFFF00093, 32'h310);
        step();
        chk("addi_imm", ia.out_imm, 32'hFFFFFFFF);
        chk("addi_src_b", ia.out_src_b, 0);
        chk("addi_regw", ia.out_reg_write, 1);
        drive(1'b1, 1'b1, 32'h4010D093, 32'h314);
        step();
        chk("srai_alu", ia.out_alu_op, 7);
        chk("srai_illegal", ia.out_illegal, 0);
        drive(1'b1, 1'b1, 32'h40009093, 32'h318);
        step();
        chk("slli_bad_illegal", ia.out_illegal, 1);
        drive(1'b1, 1'b1, 32'hFE000EE3, 32'h31C);
        step();
        chk("beq_imm", ia.out_imm, 32'hFFFFFFFC);
        chk("beq_branch", ia.out_branch, 1);
        chk("beq_src_a", ia.out_src_a, 1);
        chk("beq_regw", ia.out_reg_write, 0);
        // asynchronous reset with a valid bundle held
        ctl(1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_valid", ia.out_valid, 0);
        chk("areset_imm", ia.out_imm, 0);
        chk("areset_pc", ia.out_pc, 0);
        chk("areset_branch", ia.out_branch, 0);
        chk("areset_in_ready", ia.in_ready, 0);
        @(negedge clk) resetn = 1'b1;
        ctl(1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h002081B3, 32'h400);
        chk("post_rst_idle", ia.out_valid, 0);
        step();
        chk("post_rst_valid", ia.out_valid, 1);
        chk("post_rst_pc", ia.out_pc, 32'h400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage. It sits between fetch and execute and generates the full control bundle plus immediate for one instruction per cycle, using a valid/ready handshake on both sides. It adds three things the current decoder lacks: load-use hazard bubbling, flush, and illegal-instruction flagging. The M-extension multiply decode is optional.

Parameters:
PC_W, 32, width of program counter carried with the instruction
ENABLE_M, 0, 1 = decode MUL/MULH/MULHSU/MULHU; DIV/REM always illegal
HAZARD_EN, 1, 1 = insert load-use bubble; 0 = never bubble (forwarding handled elsewhere)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts in_instr/in_pc this cycle
in_instr  in  32  raw instruction
in_pc  in  PC_W  address of in_instr
flush  in  1  kill stage contents (taken branch/jump)
out_valid  out  1  control bundle valid for execute
out_ready  in  1  execute accepts bundle
out_pc  out  PC_W  registered pc
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_imm  out  32  sign-extended immediate (I/S/B/U/J)
out_alu_op  out  4  alu_op_e encoding
out_src_a  out  2  0 rs1, 1 pc, 2 zero
out_src_b  out  1  0 imm, 1 rs2
out_wb_sel  out  2  0 alu, 1 load, 2 pc+4
out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each
out_funct3  out  3  branch condition / memory size
out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, resetn=0): out_valid=0 and every out_* = 0; in_ready=0 while in reset. Reset mid-transfer drops the bundle.
- Latency: 1 cycle, accept edge to out_valid.
- in_ready = !flush && !hazard && (!out_valid || out_ready). Transfer occurs when in_valid && in_ready.
- On transfer, the register loads the decoded bundle and out_valid=1. Else if out_ready, out_valid=0. Else the register holds its value, stable while out_valid && !out_ready.
- hazard (HAZARD_EN=1): out_valid && out_mem_read && out_rd!=0 && in_valid && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
  - When hazard && out_ready, the register loads a bubble (out_valid=0) and in_ready=0. The next cycle accepts normally, giving exactly 1 bubble.
  - uses_rs1 is false for LUI/AUIPC/JAL; uses_rs2 only for R, S, B.
- flush: out_valid<=0 next edge; in_ready=0 that cycle. Flush overrides hazard and transfer.
- Decode, per opcode:
  - R-type: src_b=1, wb=alu.
  - I-ALU: src_b=0. SLLI/SRLI/SRAI with imm[11:5] not 0000000/0100000 (SRAI) are illegal.
  - LOAD: mem_read=1, wb=load.
  - STORE: mem_write=1, reg_write=0.
  - BRANCH: branch=1, src_a=pc.
  - JAL: jump=1, src_a=pc, wb=pc+4.
  - JALR: jump=1, src_a=rs1, wb=pc+4.
  - LUI: src_a=zero.
  - AUIPC: src_a=pc.
- alu_op_e values: ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9. MUL11 MULH12 MULHSU13 MULHU14 apply only when ENABLE_M=1 and funct7=0000001. SUB/SRA are selected by funct7=0100000; SRAI by imm[10].
- rd==0 forces reg_write=0.
- Illegal covers: unknown opcode, bad funct7/funct3, M ops when disabled, and DIV/REM. On illegal: out_illegal=1, reg_write=mem_read=mem_write=branch=jump=0; the bundle still transfers with out_valid=1.
- out_funct3 is in_instr[14:12] for all types.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams
  - alu_op_e (4-bit)
  - src_a_e, wb_sel_e
  - ctrl_t packed struct (all bundle fields)
- Sub-module rv_decode_comb: pure combinational instr -> ctrl_t + immediate, with the ENABLE_M parameter.
- The top holds the handshake, hazard and register logic.

Test Plan:
- Reset: resetn=0 mid-stream with out_valid=1 -> out_valid=0 and all outputs 0 immediately, asynchronously; after release, first accepted instr appears 1 cycle later.
- in_instr=0x002081B3 (add x3,x1,x2), pc=0x100, out_ready=1 -> next cycle out_valid=1, alu_op=0, rd=3, src_b=1, reg_write=1, out_pc=0x100. Then 0x40208133 -> alu_op=1 (SUB), rd=2.
- 0x0000A283 (lw x5,0(x1)) followed by 0x00028333 (add x6,x5,x0), out_ready=1 -> one cycle with out_valid=0 and in_ready=0, then add emitted. Same sequence with HAZARD_EN=0 -> no bubble.
- out_ready=0 for 3 cycles holding 0x0000A283 -> bundle stable, in_ready=0; then flush=1 -> out_valid=0 next edge, held bundle discarded.
- 0xFFFFFFFF -> out_illegal=1, reg_write=0, mem_write=0. 0x023100B3 (mul x1,x2,x3): ENABLE_M=1 -> alu_op=11; ENABLE_M=0 -> out_illegal=1.
- 0x00000013 (addi x0,x0,0) -> reg_write=0, illegal=0. 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, src_b=0.
